// File: rtl/seq_arith_unit.sv
// Clocked valid/ready arithmetic unit: single-cycle ADD/SUB, iterative shift-add MULT and
// restoring DIV (one bit per cycle), with full-width results and status flags.
module seq_arith_unit #(
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 4,
    // Opcode encodings; override to match the instruction-set definitions.
    parameter logic [OPCODE_WIDTH-1:0] OP_NOP  = OPCODE_WIDTH'(0),
    parameter logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(1),
    parameter logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(2),
    parameter logic [OPCODE_WIDTH-1:0] OP_MULT = OPCODE_WIDTH'(3),
    parameter logic [OPCODE_WIDTH-1:0] OP_DIV  = OPCODE_WIDTH'(4)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] op,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_lo,
    output logic [DATA_WIDTH-1:0]   out_hi,
    output logic                    carry,
    output logic                    div_zero,
    output logic                    op_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                  state, next_state;
    logic [CNT_W-1:0]        cnt;
    logic                    is_div;
    logic [DATA_WIDTH-1:0]   opnd;   // multiplicand or divisor
    logic [DATA_WIDTH-1:0]   acc;    // product high half or partial remainder
    logic [DATA_WIDTH-1:0]   shreg;  // multiplier shifting out / quotient shifting in

    logic                    accept;
    logic [DATA_WIDTH:0]     add_sum;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH:0]     div_shift;
    logic                    div_ge;
    logic [DATA_WIDTH:0]     div_diff;
    logic [DATA_WIDTH-1:0]   iter_acc, iter_shreg;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign add_sum   = {1'b0, in_a} + {1'b0, in_b};

    // One iteration of either algorithm, selected by the captured opcode.
    assign mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc, shreg[DATA_WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift - {1'b0, opnd};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        iter_acc   = mul_sum[DATA_WIDTH:1];
        iter_shreg = {mul_sum[0], shreg[DATA_WIDTH-1:1]};
        if (is_div) begin
            iter_acc   = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
            iter_shreg = {shreg[DATA_WIDTH-2:0], div_ge};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_NOP:  next_state = IDLE;
                        OP_ADD:  next_state = DONE;
                        OP_SUB:  next_state = DONE;
                        OP_MULT: next_state = EXEC;
                        OP_DIV:  next_state = (in_b == '0) ? DONE : EXEC;
                        default: next_state = DONE;
                    endcase
                end
            end
            EXEC:    if (cnt == LAST_ITER) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            shreg    <= '0;
            out_lo   <= '0;
            out_hi   <= '0;
            carry    <= 1'b0;
            div_zero <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry    <= 1'b0;
                        div_zero <= 1'b0;
                        op_err   <= 1'b0;
                        case (op)
                            OP_NOP: ;
                            OP_ADD: begin
                                out_lo <= add_sum[DATA_WIDTH-1:0];
                                out_hi <= '0;
                                carry  <= add_sum[DATA_WIDTH];
                            end
                            OP_SUB: begin
                                out_lo <= in_a - in_b;
                                out_hi <= '0;
                                carry  <= (in_a < in_b);
                            end
                            OP_MULT: begin
                                is_div <= 1'b0;
                                opnd   <= in_a;
                                shreg  <= in_b;
                                acc    <= '0;
                                cnt    <= '0;
                            end
                            OP_DIV: begin
                                if (in_b == '0) begin
                                    out_lo   <= '1;
                                    out_hi   <= in_a;
                                    div_zero <= 1'b1;
                                end else begin
                                    is_div <= 1'b1;
                                    opnd   <= in_b;
                                    shreg  <= in_a;
                                    acc    <= '0;
                                    cnt    <= '0;
                                end
                            end
                            default: begin
                                out_lo <= '0;
                                out_hi <= '0;
                                op_err <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    acc   <= iter_acc;
                    shreg <= iter_shreg;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        out_hi <= iter_acc;
                        out_lo <= iter_shreg;
                    end
                end
                default: ;  // DONE holds results until consumed
            endcase
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit at DATA_WIDTH=8: latency, results, flags, backpressure,
// async reset mid-operation, NOP and illegal opcode.
module tb_seq_arith_unit;

    localparam int W = 8;
    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, MULT = 4'd3, DIV = 4'd4;
    localparam logic [3:0] BAD = 4'd15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = NOP;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_lo, out_hi;
    logic         carry, div_zero, op_err;

    int checks = 0;
    int errors = 0;
    int lat;
    int seen;
    logic ready_seen;

    seq_arith_unit #(.DATA_WIDTH(W), .OPCODE_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_lo(out_lo), .out_hi(out_hi),
        .carry(carry), .div_zero(div_zero), .op_err(op_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request, then count edges from the accepting edge until out_valid rises.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op = o; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = ADD; in_a = 8'hA5; in_b = 8'h5A;
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 50) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_lo,
                          input logic [W-1:0] exp_hi, input logic [2:0] exp_flags);
        issue(o, a, b);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " out_lo"}, out_lo, exp_lo);
        check({tag, " out_hi"}, out_hi, exp_hi);
        check({tag, " flags"}, {carry, div_zero, op_err}, exp_flags);
        check({tag, " busy"}, {ready_seen, in_ready}, 2'b00);
        @(posedge clk); #1;
        check({tag, " drained"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #12;
        check("reset ready/valid", {in_ready, out_valid}, 2'b10);
        check("reset data", {out_hi, out_lo}, 16'h0000);
        check("reset flags", {carry, div_zero, op_err}, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        //        tag          op    a      b      lat  lo     hi     {carry,dz,err}
        run_op("add 200+100", ADD,  8'd200, 8'd100, 1, 8'h2C, 8'h00, 3'b100);
        run_op("add 255+1",   ADD,  8'd255, 8'd1,   1, 8'h00, 8'h00, 3'b100);
        run_op("sub 5-7",     SUB,  8'd5,   8'd7,   1, 8'hFE, 8'h00, 3'b100);
        run_op("sub 7-5",     SUB,  8'd7,   8'd5,   1, 8'h02, 8'h00, 3'b000);
        run_op("mult 200*3",  MULT, 8'd200, 8'd3,   9, 8'h58, 8'h02, 3'b000);
        run_op("mult 255*255",MULT, 8'd255, 8'd255, 9, 8'h01, 8'hFE, 3'b000);
        run_op("div 100/7",   DIV,  8'd100, 8'd7,   9, 8'd14, 8'd2,  3'b000);
        run_op("div 255/1",   DIV,  8'd255, 8'd1,   9, 8'hFF, 8'h00, 3'b000);
        run_op("div 7/9",     DIV,  8'd7,   8'd9,   9, 8'h00, 8'h07, 3'b000);
        run_op("div 9/0",     DIV,  8'd9,   8'd0,   1, 8'hFF, 8'h09, 3'b010);
        run_op("bad opcode",  BAD,  8'd33,  8'd44,  1, 8'h00, 8'h00, 3'b001);

        // NOP: accepted, stays idle, never raises out_valid.
        @(negedge clk);
        op = NOP; in_a = 8'd1; in_b = 8'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid || !in_ready) seen++;
            @(posedge clk); #1;
        end
        check("nop no result", seen, 0);

        // Backpressure: result held while out_ready is low, new requests ignored.
        out_ready = 1'b0;
        issue(ADD, 8'd10, 8'd20);
        check("bp latency", lat, 1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = SUB; in_a = 8'd3; in_b = 8'(i);
            @(posedge clk); #1;
            if (!out_valid || in_ready || out_lo !== 8'h1E || out_hi !== 8'h00 ||
                {carry, div_zero, op_err} !== 3'b000)
                seen++;
        end
        check("bp hold", seen, 0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release", {out_valid, in_ready}, 2'b01);

        // Async reset in the fourth EXEC cycle of a MULT.
        issue(DIV, 8'd9, 8'd0);
        @(posedge clk); #1;
        @(negedge clk);
        op = MULT; in_a = 8'd200; in_b = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst mid-mult ready/valid", {in_ready, out_valid}, 2'b10);
        check("rst mid-mult data", {out_hi, out_lo}, 16'h0000);
        check("rst mid-mult flags", {carry, div_zero, op_err}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no stale result", seen, 0);

        run_op("post-rst add", ADD, 8'd1, 8'd2, 1, 8'h03, 8'h00, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
